// File: rtl/and_gate_2in.sv
// Bitwise two-input AND with a combinational result and an enabled, resettable
// registered copy. Each bit position is an independent lane.

module and_gate_2in_lane (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic out,
    output logic out_q
);

    // A 0 on either side forces 0, even when the other operand is X or Z.
    assign out = a & b;

    always_ff @(posedge clk) begin
        if (reset)
            out_q <= 1'b0;
        else if (en)
            out_q <= a & b;
    end

endmodule

module and_gate_2in #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            and_gate_2in_lane u_lane (
                .clk   (clk),
                .reset (reset),
                .en    (en),
                .a     (a[i]),
                .b     (b[i]),
                .out   (out[i]),
                .out_q (out_q[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_and_gate_2in.sv
// Directed bench for and_gate_2in at WIDTH=1 (extender use) and WIDTH=8 (registered path).

module tb_and_gate_2in;

    logic       clk = 1'b0;
    logic       reset;
    logic       a1, b1, en1;
    logic       out1, out_q1;
    logic [7:0] a8, b8;
    logic       en8;
    logic [7:0] out8, out_q8;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    and_gate_2in #(.WIDTH(1)) u_w1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .en(en1),
        .out(out1), .out_q(out_q1)
    );

    and_gate_2in #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .en(en8),
        .out(out8), .out_q(out_q8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference register behaviour: reset beats enable, enable loads, otherwise hold.
    logic [7:0] m_q8;
    logic       m_q1;
    logic       m_vld = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q8  <= 8'h00;
            m_q1  <= 1'b0;
            m_vld <= 1'b1;
        end else begin
            if (en8) m_q8 <= a8 & b8;
            if (en1) m_q1 <= a1 & b1;
        end
    end

    // Per-cycle comparison, sampled on the falling edge away from input changes.
    always @(negedge clk) begin
        if (m_vld) begin
            chk("cmp_out8",   {56'd0, out8},   {56'd0, a8 & b8});
            chk("cmp_out_q8", {56'd0, out_q8}, {56'd0, m_q8});
            chk("cmp_out1",   {63'd0, out1},   {63'd0, a1 & b1});
            chk("cmp_out_q1", {63'd0, out_q1}, {63'd0, m_q1});
        end
    end

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  tt_exp;
    logic [63:0] in_word;
    logic [63:0] ext;

    initial begin
        reset = 1'b1; en1 = 1'b1; en8 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        edge1();
        chk("reset_out_q8", {56'd0, out_q8}, 64'h0);
        chk("reset_out_q1", {63'd0, out_q1}, 64'h0);
        reset = 1'b0;

        // WIDTH=1 truth table, no clock edge needed
        tt_exp = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            a1 = i[1]; b1 = i[0];
            #1;
            chk($sformatf("tt_%0d%0d", a1, b1), {63'd0, out1}, {63'd0, tt_exp[i]});
        end

        // Sign-extension gating: sign AND in[8], replicated into bits 63:9
        in_word = 64'h0000_0000_0000_0123;
        a1 = 1'b1; b1 = in_word[8]; #1;
        ext = {{55{out1}}, in_word[8:0]};
        chk("ext_s1_m1", ext, 64'hFFFF_FFFF_FFFF_FF23);
        in_word = 64'h0000_0000_0000_00A5;
        a1 = 1'b1; b1 = in_word[8]; #1;
        ext = {{55{out1}}, in_word[8:0]};
        chk("ext_s1_m0", ext, 64'h0000_0000_0000_00A5);
        in_word = 64'h0000_0000_0000_0123;
        a1 = 1'b0; b1 = in_word[8]; #1;
        ext = {{55{out1}}, in_word[8:0]};
        chk("ext_s0_m1", ext, 64'h0000_0000_0000_0123);

        // WIDTH=8 registered path
        a8 = 8'hF0; b8 = 8'h3C; #1;
        chk("comb_f0_3c", {56'd0, out8}, 64'h30);
        edge1();
        chk("q_f0_3c", {56'd0, out_q8}, 64'h30);
        a8 = 8'hFF; b8 = 8'hAA;
        edge1();
        chk("q_ff_aa", {56'd0, out_q8}, 64'hAA);

        // Hold with en=0
        a8 = 8'hF0; b8 = 8'h3C;
        edge1();
        chk("q_reload_30", {56'd0, out_q8}, 64'h30);
        en8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            edge1();
            chk($sformatf("hold_q_%0d", k),   {56'd0, out_q8}, 64'h30);
            chk($sformatf("hold_out_%0d", k), {56'd0, out8},   64'hFF);
        end

        // Reset wins over enable
        en8 = 1'b1; a8 = 8'hFF; b8 = 8'hAA;
        edge1();
        chk("pre_rst_q", {56'd0, out_q8}, 64'hAA);
        reset = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        edge1();
        chk("rst_prio_q",   {56'd0, out_q8}, 64'h00);
        chk("rst_prio_out", {56'd0, out8},   64'hFF);
        reset = 1'b0;
        edge1();
        chk("post_rst_q", {56'd0, out_q8}, 64'hFF);

        // A few mixed patterns through the per-cycle comparator
        a8 = 8'h5A; b8 = 8'hC3; edge1();
        chk("q_5a_c3", {56'd0, out_q8}, 64'h42);
        a8 = 8'h81; b8 = 8'h7E; edge1();
        chk("q_81_7e", {56'd0, out_q8}, 64'h00);

        // Unknown operand: 0 dominates; a 1 passes the unknown through
        a1 = 1'b0; b1 = 1'bx; #1;
        chk("x_a0", {63'd0, out1}, 64'h0);
        a1 = 1'b1; #1;
        chk("x_a1", {63'd0, out1}, {63'd0, b1});
        b1 = 1'b0;

        edge1();
        edge1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
